// File: rtl/deser_arb_pkg.sv
// Shared state encoding and default sizing for the serial-channel deserializer arbiter.
package deser_arb_pkg;

    localparam int DEF_WD     = 8;
    localparam int DEF_NUM_CH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/deser_rr_pick.sv
// Combinational round-robin pick: first requester after i_last, wrapping around.
module deser_rr_pick #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IDX_W-1:0]  i_last,
    output logic [NUM_CH-1:0] o_onehot,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_any
);

    logic w_found;

    always_comb begin
        w_found  = 1'b0;
        o_idx    = '0;
        o_onehot = '0;
        o_any    = |i_req;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!w_found && i_req[IDX_W'((int'(i_last) + k) % NUM_CH)]) begin
                w_found = 1'b1;
                o_idx   = IDX_W'((int'(i_last) + k) % NUM_CH);
            end
        end
        o_onehot[o_idx] = w_found;
    end

endmodule

// File: rtl/deser_arbiter.sv
// Round-robin arbiter over NUM_CH serial requesters; deserializes the granted
// channel LSB-first into a single-entry output register with a one-word park slot.
module deser_arbiter
    import deser_arb_pkg::*;
#(
    parameter int DESERIALIZER_WD = DEF_WD,
    parameter int NUM_CH          = DEF_NUM_CH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           req,
    input  logic [NUM_CH-1:0]           valid_in,
    input  logic [NUM_CH-1:0]           data_in,
    output logic [NUM_CH-1:0]           gnt,
    output logic [DESERIALIZER_WD-1:0]  data_out,
    output logic [$clog2(NUM_CH)-1:0]   ch_out,
    output logic                        valid_out,
    input  logic                        ready_in,
    output logic                        abort
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(DESERIALIZER_WD + 1);
    localparam int WD    = DESERIALIZER_WD;

    state_e            r_state, w_state_nxt;
    logic [NUM_CH-1:0] r_gnt;
    logic [CH_W-1:0]   r_sel, r_last, r_hold_ch, r_ch_out;
    logic [CNT_W-1:0]  r_cnt;
    logic [WD-1:0]     r_shift, r_hold_data, r_data_out;
    logic              r_valid, r_abort;

    logic [NUM_CH-1:0] w_pick_oh;
    logic [CH_W-1:0]   w_pick_idx;
    logic              w_pick_any;
    logic              w_bit, w_done, w_drain;
    logic [WD-1:0]     w_shift_nxt;
    logic              w_grant, w_release, w_shift_en, w_load_new, w_load_held, w_park, w_abort;

    deser_rr_pick #(.NUM_CH(NUM_CH), .IDX_W(CH_W)) u_pick (
        .i_req    (req),
        .i_last   (r_last),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    assign w_bit       = valid_in[r_sel];
    assign w_shift_nxt = {data_in[r_sel], r_shift[WD-1:1]};
    assign w_done      = w_bit && (r_cnt == CNT_W'(WD - 1));
    assign w_drain     = r_valid && ready_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Completion outranks a dropped request so a last bit paired with req falling still lands.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_release   = 1'b0;
        w_shift_en  = 1'b0;
        w_load_new  = 1'b0;
        w_load_held = 1'b0;
        w_park      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_grant     = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (w_done) begin
                    w_release = 1'b1;
                    if (!r_valid || ready_in) begin
                        w_load_new  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_park      = 1'b1;
                        w_state_nxt = HOLD;
                    end
                end else if (!req[r_sel]) begin
                    w_abort     = 1'b1;
                    w_release   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_bit) begin
                    w_shift_en = 1'b1;
                end
            end
            HOLD: begin
                if (ready_in) begin
                    w_load_held = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt   <= '0;
            r_sel   <= '0;
            r_last  <= CH_W'(NUM_CH - 1);
            r_cnt   <= '0;
            r_shift <= '0;
            r_abort <= 1'b0;
        end else begin
            r_abort <= w_abort;
            if (w_grant) begin
                r_gnt  <= w_pick_oh;
                r_sel  <= w_pick_idx;
                r_last <= w_pick_idx;
                r_cnt  <= '0;
            end else if (w_release) begin
                r_gnt <= '0;
                r_cnt <= '0;
            end else if (w_shift_en) begin
                r_shift <= w_shift_nxt;
                r_cnt   <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_data <= '0;
            r_hold_ch   <= '0;
            r_data_out  <= '0;
            r_ch_out    <= '0;
            r_valid     <= 1'b0;
        end else begin
            if (w_park) begin
                r_hold_data <= w_shift_nxt;
                r_hold_ch   <= r_sel;
            end
            if (w_load_new) begin
                r_data_out <= w_shift_nxt;
                r_ch_out   <= r_sel;
                r_valid    <= 1'b1;
            end else if (w_load_held) begin
                r_data_out <= r_hold_data;
                r_ch_out   <= r_hold_ch;
                r_valid    <= 1'b1;
            end else if (w_drain) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign gnt       = r_gnt;
    assign data_out  = r_data_out;
    assign ch_out    = r_ch_out;
    assign valid_out = r_valid;
    assign abort     = r_abort;

endmodule

// File: tb/tb_deser_arbiter.sv
// Directed bench for deser_arbiter: single word, fairness, gapped strobes,
// backpressure parking, abort and asynchronous reset mid-word.
module tb_deser_arbiter;

    localparam int WD = 8;
    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NC-1:0] req, valid_in, data_in, gnt;
    logic [WD-1:0] data_out;
    logic [1:0]    ch_out;
    logic          valid_out, ready_in, abort;

    int n_chk = 0;
    int n_err = 0;

    deser_arbiter #(.DESERIALIZER_WD(WD), .NUM_CH(NC)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .gnt       (gnt),
        .data_out  (data_out),
        .ch_out    (ch_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .abort     (abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0; req = '0; valid_in = '0; data_in = '0; ready_in = 1'b1;
        tick; tick;
        chk("rst_gnt",   32'(gnt), 0);
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_abort", 32'(abort), 0);
        chk("rst_data",  32'(data_out), 0);
        chk("rst_ch",    32'(ch_out), 0);
        rst = 1'b1;
    endtask

    // Bits lo..hi-1 of w on channel ch; other channels strobe every cycle with inverted data.
    task automatic drive(input int ch, input logic [WD-1:0] w, input int lo, input int hi, input int gap);
        logic [NC-1:0] oh;
        oh = NC'(1) << ch;
        for (int i = lo; i < hi; i++) begin
            for (int g = 0; g < gap; g++) begin
                valid_in = ~oh; data_in = ~oh;
                tick;
            end
            valid_in = '1;
            data_in  = w[i] ? oh : ~oh;
            tick;
        end
        valid_in = '0; data_in = '0;
    endtask

    initial begin
        // single channel word
        do_reset;
        req = 4'b0001;
        tick;
        chk("single_gnt", 32'(gnt), 32'h1);
        drive(0, 8'h4D, 0, 8, 0);
        req = '0;
        chk("single_valid", 32'(valid_out), 1);
        chk("single_data",  32'(data_out), 32'h4D);
        chk("single_ch",    32'(ch_out), 0);
        chk("single_gnt_clr", 32'(gnt), 0);
        tick;
        chk("single_valid_1cyc", 32'(valid_out), 0);

        // fairness with all requesting
        do_reset;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("rr_gnt", 32'(gnt), 32'(4'b0001 << (k % 4)));
            drive(k % 4, 8'hA0 + 8'(k), 0, 8, 0);
            chk("rr_valid", 32'(valid_out), 1);
            chk("rr_ch",    32'(ch_out), 32'(k % 4));
            chk("rr_data",  32'(data_out), 32'(8'hA0 + 8'(k)));
        end
        req = '0;
        tick;

        // gapped strobes on ch 1
        do_reset;
        req = 4'b0010;
        tick;
        chk("gap_gnt", 32'(gnt), 32'h2);
        drive(1, 8'h3C, 0, 7, 2);
        chk("gap_not_yet", 32'(valid_out), 0);
        drive(1, 8'h3C, 7, 8, 2);
        req = '0;
        chk("gap_valid", 32'(valid_out), 1);
        chk("gap_data",  32'(data_out), 32'h3C);
        chk("gap_ch",    32'(ch_out), 1);

        // backpressure: ch 2 word parked in output, ch 3 word held
        do_reset;
        ready_in = 1'b0;
        req = 4'b1100;
        tick;
        chk("bp_gnt2", 32'(gnt), 32'h4);
        drive(2, 8'h5A, 0, 8, 0);
        chk("bp_valid2", 32'(valid_out), 1);
        tick;
        chk("bp_gnt3", 32'(gnt), 32'h8);
        drive(3, 8'hC3, 0, 8, 0);
        chk("bp_hold_gnt", 32'(gnt), 0);
        chk("bp_hold_data", 32'(data_out), 32'h5A);
        repeat (3) tick;
        chk("bp_no_third", 32'(gnt), 0);
        chk("bp_still_valid", 32'(valid_out), 1);
        chk("bp_still_ch", 32'(ch_out), 2);
        req = '0; ready_in = 1'b1;
        tick;
        chk("bp_second_valid", 32'(valid_out), 1);
        chk("bp_second_data",  32'(data_out), 32'hC3);
        chk("bp_second_ch",    32'(ch_out), 3);
        tick;
        chk("bp_drained", 32'(valid_out), 0);

        // abort after 5 bits on ch 2
        do_reset;
        req = 4'b1100;
        tick;
        chk("ab_gnt2", 32'(gnt), 32'h4);
        drive(2, 8'hFF, 0, 5, 0);
        req = 4'b1001;
        tick;
        chk("ab_pulse", 32'(abort), 1);
        chk("ab_gnt_clr", 32'(gnt), 0);
        chk("ab_no_valid", 32'(valid_out), 0);
        tick;
        chk("ab_pulse_end", 32'(abort), 0);
        chk("ab_next_gnt", 32'(gnt), 32'h8);
        drive(3, 8'h81, 0, 8, 0);
        req = '0;
        chk("ab_next_data", 32'(data_out), 32'h81);
        chk("ab_next_ch",   32'(ch_out), 3);
        tick;

        // async reset mid-word with an output pending
        do_reset;
        ready_in = 1'b0;
        req = 4'b0010;
        tick;
        drive(1, 8'h11, 0, 8, 0);
        chk("ar_pending", 32'(valid_out), 1);
        req = 4'b0100;
        tick;
        chk("ar_gnt2", 32'(gnt), 32'h4);
        drive(2, 8'hFF, 0, 3, 0);
        #2 rst = 1'b0;
        #1;
        chk("ar_gnt_clr",   32'(gnt), 0);
        chk("ar_valid_clr", 32'(valid_out), 0);
        chk("ar_data_clr",  32'(data_out), 0);
        req = 4'b0101; ready_in = 1'b1;
        tick;
        rst = 1'b1;
        tick;
        chk("ar_first_gnt", 32'(gnt), 32'h1);
        drive(0, 8'hE7, 0, 7, 0);
        chk("ar_cnt_fresh", 32'(valid_out), 0);
        drive(0, 8'hE7, 7, 8, 0);
        req = '0;
        chk("ar_word_valid", 32'(valid_out), 1);
        chk("ar_word_data",  32'(data_out), 32'hE7);
        chk("ar_word_ch",    32'(ch_out), 0);
        tick;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/deser_arbiter.md
DESER_ARBITER -- requirements
Module: deser_arbiter

Interface
REQ-001 SHALL have parameter DESERIALIZER_WD, default 8, word width in bits (>=2).
REQ-002 SHALL have parameter NUM_CH, default 4, number of serial requesters (>=2).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port req, input, NUM_CH, per-channel request; held high for the whole word.
REQ-006 SHALL have port valid_in, input, NUM_CH, per-channel serial bit strobe.
REQ-007 SHALL have port data_in, input, NUM_CH, per-channel serial data bit.
REQ-008 SHALL have port gnt, output, NUM_CH, registered one-hot grant.
REQ-009 SHALL have port data_out, output, DESERIALIZER_WD, assembled word.
REQ-010 SHALL have port ch_out, output, $clog2(NUM_CH), channel index of data_out.
REQ-011 SHALL have port valid_out, output, 1, data_out/ch_out valid; held until accepted.
REQ-012 SHALL have port ready_in, input, 1, downstream accept; transfer when valid_out && ready_in.
REQ-013 SHALL have port abort, output, 1, one-cycle pulse when a partial word is discarded.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, HOLD.
REQ-015 IDLE: if any req bit is high, SHALL pick the first requesting channel searching from last_grant+1 with wrap-around, set gnt one-hot for it, clear the bit counter, and go BUSY.
REQ-016 IDLE with no req SHALL keep gnt all-zero and stay IDLE.
REQ-017 BUSY: on each cycle with valid_in[sel] high, SHALL shift data_in[sel] into the MSB of the shift register (shift right, LSB-first) and increment the bit counter; valid_in/data_in of non-granted channels SHALL be ignored.
REQ-018 The bit counter SHALL be $clog2(DESERIALIZER_WD+1) bits wide; a word completes on the edge sampling bit DESERIALIZER_WD.
REQ-019 On completion, if the output register is empty or drains that same cycle, SHALL load data_out/ch_out, assert valid_out, clear gnt, and go IDLE on that same edge.
REQ-020 On completion with valid_out high and ready_in low, SHALL clear gnt, keep the word internally, and go HOLD.
REQ-021 HOLD SHALL move the held word into the output register on the cycle ready_in accepts the old word, then go IDLE; valid_out SHALL stay high across that transfer.
REQ-022 BUSY with req[sel] low (and word incomplete) SHALL discard the partial word, pulse abort for one cycle, clear gnt, and go IDLE; last_grant SHALL still update.
REQ-023 If req[sel] drops on the same edge the last bit completes, SHALL treat it as completion, not abort.
REQ-024 last_grant SHALL update to sel at each grant; minimum gap between consecutive grants is one IDLE cycle.
REQ-025 The output register SHALL be single-entry; valid_out SHALL clear only on accept with no new load.

Reset
REQ-026 Reset SHALL force IDLE, gnt=0, valid_out=0, abort=0, data_out=0, ch_out=0, bit counter=0, and last_grant=NUM_CH-1 so channel 0 wins first.
REQ-027 Reset mid-word or in HOLD SHALL drop all partial and held data with no output.

Structure
REQ-028 Package deser_arb_pkg SHALL hold the state enum and the default width/channel constants.
REQ-029 Round-robin selection SHALL be a combinational sub-module deser_rr_pick (req, last_grant -> one-hot, index, any).

Verification
REQ-030 Single channel: req[0]=1, bits 1,0,1,1,0,0,1,0 LSB-first with ready_in=1 -> data_out=8'h4D, ch_out=0, valid_out for 1 cycle.
REQ-031 Fairness: all req high continuously -> grant order 0,1,2,3,0; each word tagged with the matching ch_out.
REQ-032 Gapped strobes: valid_in[1] high every 3rd cycle -> word completes after 8 strobes; value is unchanged; non-granted strobes have no effect.
REQ-033 Backpressure: ready_in=0 while two words from ch 2 then ch 3 complete -> FSM in HOLD, no third grant; raise ready_in -> ch 2 word, then ch 3 word, in order.
REQ-034 Abort: drop req[2] after 5 bits -> abort pulses once, no valid_out, next grant goes to ch 3.
REQ-035 Async reset asserted mid-word in BUSY -> gnt, valid_out and the counter clear immediately; the first grant after reset goes to ch 0.
